// File: rtl/bf_accum_array_if.sv
// Beat/result bus for the multi-lane partial-sum accumulator.
// Latency: none (wires only); the slave side registers the result.
// Backpressure: in_ready/out_ready valid-ready handshakes on both sides.
interface bf_accum_array_if #(
  parameter int CH    = 4,
  parameter int IN_W  = 20,
  parameter int ACC_W = 28,
  parameter int CNT_W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CH*IN_W-1:0]    in_sum;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [CH*ACC_W-1:0]   out_data;
  logic [CH-1:0]         out_ovf;
  logic [CNT_W-1:0]      out_cnt;

  // Upstream producer / downstream consumer side
  modport master (
    output in_valid, in_sum, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_cnt
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_sum, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_cnt
  );
endinterface

// File: rtl/bf_accum_array.sv
// Sums CH lanes of signed partial sums per in_last-delimited group; optional clamp via BF_ACC_SATURATE_EN.
// Latency: 1 cycle, result is valid on the edge that accepts the last beat.
// Backpressure: in_ready = !clr && (!out_valid || out_ready); a held result stalls every beat.
module bf_accum_array #(
  parameter int CH    = 4,
  parameter int IN_W  = 20,
  parameter int ACC_W = 28,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  bf_accum_array_if.slave bus
);

`ifdef BF_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  typedef enum logic {S_EMPTY = 1'b0, S_ACCUM = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [CH-1:0][IN_W-1:0]     lane_c;
  logic [CH-1:0][ACC_W:0]      wide_c;
  logic [CH-1:0][ACC_W-1:0]    acc_q, acc_d;
  logic [CH-1:0]               ovf_q, ovf_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CH-1:0][ACC_W-1:0]    out_data_q;
  logic [CH-1:0]               out_ovf_q;
  logic [CNT_W-1:0]            out_cnt_q;
  logic                        out_valid_q, out_valid_d;
  logic                        in_ready_c, accept, take_last, take_mid;
  logic                        first;

  assign lane_c = bus.in_sum;
  assign first  = (state_q == S_EMPTY);

  // Control state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_EMPTY;
    else          state_q <= state_d;
  end

  // Next control state: clr aborts the group, a last beat closes it
  always_comb begin
    state_d = state_q;
    if (clr)         state_d = S_EMPTY;
    else if (accept) state_d = bus.in_last ? S_EMPTY : S_ACCUM;
  end

  // Handshake decode; in_ready never looks at in_valid
  always_comb begin
    in_ready_c = !clr && (!out_valid_q || bus.out_ready);
    accept     = bus.in_valid && in_ready_c;
    take_last  = accept && bus.in_last;
    take_mid   = accept && !bus.in_last;
  end

  // Per-lane sum one bit wider than the accumulator so overflow is visible
  always_comb begin
    wide_c = '0;
    acc_d  = '0;
    ovf_d  = '0;
    for (int i = 0; i < CH; i++) begin
      wide_c[i] = (first ? {(ACC_W+1){1'b0}} : {acc_q[i][ACC_W-1], acc_q[i]})
                + {{(ACC_W+1-IN_W){lane_c[i][IN_W-1]}}, lane_c[i]};
      ovf_d[i]  = (wide_c[i][ACC_W] != wide_c[i][ACC_W-1]) | (!first && ovf_q[i]);
`ifdef BF_ACC_SATURATE_EN
      if (wide_c[i][ACC_W] != wide_c[i][ACC_W-1])
        acc_d[i] = wide_c[i][ACC_W] ? ACC_MIN : ACC_MAX;
      else
        acc_d[i] = wide_c[i][ACC_W-1:0];
`else
      acc_d[i]  = wide_c[i][ACC_W-1:0];
`endif
    end
  end

  // Beat count restarts at 1 for a new group and sticks at all-ones
  always_comb begin
    if (first)      cnt_d = CNT_W'(1);
    else if (&cnt_q) cnt_d = cnt_q;
    else            cnt_d = cnt_q + CNT_W'(1);
  end

  // Running accumulation for non-last beats; clr discards it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      ovf_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
      ovf_q <= '0;
      cnt_q <= '0;
    end else if (take_mid) begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  // Result stays valid across a handshake if a new last beat lands the same cycle
  always_comb begin
    out_valid_d = take_last || (out_valid_q && !bus.out_ready);
  end

  // One-entry result register, untouched by clr
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= '0;
      out_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (take_last) begin
        out_data_q <= acc_d;
        out_ovf_q  <= ovf_d;
        out_cnt_q  <= cnt_d;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_bf_accum_array.sv
// Randomised and directed bench for bf_accum_array with a scoreboard-fed monitor.
// Latency: expects the result on the edge that accepts the last beat.
// Backpressure: drives random out_ready and checks in_ready stalls.
module tb_bf_accum_array;
  localparam int CH    = 4;
  localparam int IN_W  = 20;
  localparam int ACC_W = 28;
  localparam int CNT_W = 8;
  localparam longint MAXV = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint MINV = -(longint'(1) << (ACC_W-1));

  typedef int lanes_t [CH];
  typedef struct packed {
    logic [CH*ACC_W-1:0] data;
    logic [CH-1:0]       ovf;
    logic [CNT_W-1:0]    cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clr = 1'b0;

  bf_accum_array_if #(.CH(CH), .IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  bf_accum_array #(.CH(CH), .IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .bus(bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   stalls = 0;
  bit   rnd_ready_on = 0;
  exp_t sb[$];
  exp_t last_exp;

  // Reference model: true arithmetic on 64-bit integers
  longint macc [CH];
  bit     movf [CH];
  int     mcnt = 0;
  bit     in_group = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic longint wrapv(input longint s);
    longint m, r;
    m = longint'(1) << ACC_W;
    r = s & (m - 1);
    if (r > MAXV) r = r - m;
    return r;
  endfunction

  function automatic logic [CH*ACC_W-1:0] pack_acc(input lanes_t v);
    logic [CH*ACC_W-1:0] p;
    longint t;
    p = '0;
    for (int i = 0; i < CH; i++) begin
      t = longint'(v[i]);
      p[i*ACC_W +: ACC_W] = t[ACC_W-1:0];
    end
    return p;
  endfunction

  function automatic int rand_in();
    logic signed [IN_W-1:0] t;
    t = IN_W'($urandom);
    return int'(t);
  endfunction

  task automatic model_beat(input lanes_t v, input bit last);
    exp_t   e;
    longint s, base;
    for (int i = 0; i < CH; i++) begin
      base = in_group ? macc[i] : 0;
      s = base + longint'(v[i]);
      movf[i] = (in_group ? movf[i] : 1'b0) | ((s > MAXV) || (s < MINV));
`ifdef BF_ACC_SATURATE_EN
      if (s > MAXV) s = MAXV;
      else if (s < MINV) s = MINV;
`else
      s = wrapv(s);
`endif
      macc[i] = s;
    end
    mcnt = in_group ? ((mcnt < (1 << CNT_W) - 1) ? mcnt + 1 : mcnt) : 1;
    if (last) begin
      e = '0;
      for (int i = 0; i < CH; i++) begin
        s = macc[i];
        e.data[i*ACC_W +: ACC_W] = s[ACC_W-1:0];
        e.ovf[i] = movf[i];
      end
      e.cnt = CNT_W'(mcnt);
      sb.push_back(e);
      last_exp = e;
      in_group = 0;
    end else begin
      in_group = 1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken
  task automatic send(input lanes_t v, input bit last);
    bit done, rdy;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    for (int i = 0; i < CH; i++) bus.in_sum[i*IN_W +: IN_W] = v[i][IN_W-1:0];
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        model_beat(v, last);
        done = 1;
      end else begin
        stalls++;
      end
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got no in_ready want accept within 2000 cycles");
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    chk("in_ready_during_clr", 128'(bus.in_ready), 128'(0));
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_group = 0;
  endtask

  // Monitor: every output handshake is checked against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected got out_valid with data %h want no result", bus.out_data);
      end else begin
        e = sb.pop_front();
        chk("sb_data", 128'(bus.out_data), 128'(e.data));
        chk("sb_ovf",  128'(bus.out_ovf),  128'(e.ovf));
        chk("sb_cnt",  128'(bus.out_cnt),  128'(e.cnt));
      end
    end
  end

  // Random downstream readiness, enabled only in the random phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready_on) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no finish want finish before 400000");
    $fatal(1, "watchdog");
  end

  initial begin
    lanes_t v, z;
    logic [CH*ACC_W-1:0] expv;
    for (int i = 0; i < CH; i++) z[i] = 0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_sum   = '0;
    bus.out_ready = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_data", 128'(bus.out_data), 128'(0));
    chk("rst_out_ovf",  128'(bus.out_ovf),  128'(0));
    chk("rst_out_cnt",  128'(bus.out_cnt),  128'(0));

    // Three-beat group with fixed lanes
    v = '{1, -1, 100, -524288};
    send(v, 0);
    send(v, 0);
    send(v, 1);
    chk("g3_latency_valid", 128'(bus.out_valid), 128'(1));
    expv = pack_acc('{3, -3, 300, -1572864});
    chk("g3_data", 128'(bus.out_data), 128'(expv));
    chk("g3_cnt",  128'(bus.out_cnt),  128'(3));
    chk("g3_ovf",  128'(bus.out_ovf),  128'(0));

    // Single-beat negative group
    v = z; v[0] = -5;
    send(v, 1);
    chk("single_lane0", 128'(bus.out_data[ACC_W-1:0]), 128'(28'hFFFFFFB));
    chk("single_cnt",   128'(bus.out_cnt), 128'(1));

    // Backpressure: pending result blocks even non-last beats
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < CH; i++) v[i] = rand_in();
    send(v, 1);
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
      chk("bp_hold",     128'(bus.out_data), 128'(last_exp.data));
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    stalls = 0;
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < CH; i++) v[i] = rand_in();
      send(v, 1);
      chk("b2b_valid", 128'(bus.out_valid), 128'(1));
    end
    chk("b2b_stalls", 128'(stalls), 128'(0));

    // Overflow on lanes 0 (positive) and 1 (negative); count saturates
    v = z; v[0] = 524287; v[1] = -524288;
    for (int b = 0; b < 257; b++) send(v, b == 256);
`ifdef BF_ACC_SATURATE_EN
    chk("ovf_lane0", 128'(bus.out_data[ACC_W-1:0]),       128'(28'h7FFFFFF));
    chk("ovf_lane1", 128'(bus.out_data[2*ACC_W-1:ACC_W]), 128'(28'h8000000));
`else
    expv = pack_acc('{-133693697, 133693440, 0, 0});
    chk("ovf_lane0", 128'(bus.out_data[ACC_W-1:0]),       128'(expv[ACC_W-1:0]));
    chk("ovf_lane1", 128'(bus.out_data[2*ACC_W-1:ACC_W]), 128'(expv[2*ACC_W-1:ACC_W]));
`endif
    chk("ovf_flags", 128'(bus.out_ovf), 128'(4'b0011));
    chk("ovf_cnt",   128'(bus.out_cnt), 128'(255));
    v = z; v[0] = 1;
    send(v, 1);
    chk("ovf_next_clear", 128'(bus.out_ovf), 128'(0));

    // clr: pending result untouched, partial group discarded
    v = z; v[2] = 42;
    send(v, 1);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    pulse_clr();
    bus.in_valid = 1'b0;
    chk("clr_keep_valid", 128'(bus.out_valid), 128'(1));
    chk("clr_keep_data",  128'(bus.out_data),  128'(last_exp.data));
    bus.out_ready = 1'b1;
    for (int i = 0; i < CH; i++) v[i] = 7;
    send(v, 0);
    send(v, 0);
    pulse_clr();
    send(v, 1);
    expv = pack_acc('{7, 7, 7, 7});
    chk("clr_data", 128'(bus.out_data), 128'(expv));
    chk("clr_cnt",  128'(bus.out_cnt),  128'(1));

    // Random groups, random gaps, random clr, random out_ready
    rnd_ready_on = 1;
    for (int g = 0; g < 60; g++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        for (int i = 0; i < CH; i++) v[i] = rand_in();
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clk); #1;
        end
        send(v, b == len - 1);
        if (b < len - 1 && $urandom_range(0, 9) == 0) begin
          pulse_clr();
          b = len;
        end
      end
    end
    rnd_ready_on = 0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_empty", 128'(sb.size()), 128'(0));

    // Async reset with a result pending and mid-group
    for (int i = 0; i < CH; i++) v[i] = rand_in();
    send(v, 1);
    bus.out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    in_group = 0;
    chk("arst_valid", 128'(bus.out_valid), 128'(0));
    chk("arst_data",  128'(bus.out_data),  128'(0));
    chk("arst_ovf",   128'(bus.out_ovf),   128'(0));
    chk("arst_cnt",   128'(bus.out_cnt),   128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    v = z; v[3] = 1000;
    send(v, 0);
    #3;
    reset_n = 1'b0;
    #1;
    in_group = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    v = z; v[3] = 11;
    send(v, 1);
    expv = pack_acc('{0, 0, 0, 11});
    chk("arst_fresh", 128'(bus.out_data), 128'(expv));
    @(posedge clk); #1;
    chk("final_empty", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bf_accum_array.md
# bf_accum_array

Parametrised, multi-channel successor to the fusion-unit accumulator. It sums a stream of signed partial sums from the PE array into CH independent lanes, one group per dot product. A group is delimited by `in_last`. Each finished group is handed downstream through a one-entry valid/ready output register with per-lane overflow flags and a beat count. It sits between the PE-array reduction tree and the output buffer/requantiser.

## Interface
- `CH`, 4: number of parallel accumulation lanes
- `IN_W`, 20: signed partial-sum width per lane
- `ACC_W`, 28: signed accumulator width per lane (must be > IN_W)
- `CNT_W`, 8: beat-counter width
- `clk` in 1: clock, all logic on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `clr` in 1: synchronous abort of the in-progress group
- `in_valid` in 1: input beat valid
- `in_ready` out 1: input beat accepted when `in_valid && in_ready`
- `in_sum` in CH*IN_W: packed signed partial sums, lane i at [i*IN_W +: IN_W]
- `in_last` in 1: accepted beat is the final beat of the group
- `out_valid` out 1: result register holds a completed group
- `out_ready` in 1: downstream accepts result when `out_valid && out_ready`
- `out_data` out CH*ACC_W: packed signed lane results
- `out_ovf` out CH: per-lane overflow flag for the group
- `out_cnt` out CNT_W: beats in the group, saturating at 2^CNT_W-1

## Operation
- Control state is EMPTY (no beat of the current group accepted) or ACCUM (at least one beat accepted). Reset enters EMPTY.
- `in_ready = !clr && (!out_valid || out_ready)`.
- On an accepted beat, for each lane: `sum = (state==EMPTY ? 0 : acc) + sext(in_sum lane to ACC_W)`. The sum is evaluated in ACC_W+1 bits for overflow detection.
- Overflow: the (ACC_W+1)-bit sum lies outside the signed ACC_W range. The lane's sticky flag is set; it is cleared at group start (EMPTY).
- Beat counter: 1 on the first beat, +1 per beat after that, saturating at all-ones.
- Accepted beat with `in_last=0`: update `acc`, flags and count; go to ACCUM.
- Accepted beat with `in_last=1`: load the new sums, flags and count into the output registers; set `out_valid`; go to EMPTY. A single-beat group gives `out_data = sext(in_sum)` and `out_cnt = 1`.
- `out_valid` clears on an output handshake unless a new last beat is accepted in the same cycle. In that case the register reloads and `out_valid` stays 1, giving back-to-back groups at full throughput.
- `clr=1`: go to EMPTY and discard the partial accumulation, flags and count. The output register and `out_valid` are untouched. No input beat is accepted that cycle.
- Ignore `in_sum`/`in_last` when `in_valid=0`.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_ovf=0`, `out_cnt=0`, `in_ready=1` (after reset deassertion, with `clr=0`), state EMPTY, all `acc` 0.
- Latency: the result appears with `out_valid=1` on the clock edge that accepts the last beat, i.e. 1 cycle.
- Throughput: 1 beat/cycle while `out_ready=1` or `out_valid=0`.
- `in_ready` depends combinationally on `out_valid`, `out_ready` and `clr`. There is no combinational path from `in_valid` to `in_ready`.
- Backpressure: while `out_valid && !out_ready`, `in_ready=0` for all beats, including non-last beats.
- `reset_n` asserted mid-group or with a result pending: everything returns to reset values immediately, and the pending result is lost.

## Configuration
- `BF_ACC_SATURATE_EN` defined: on overflow the lane value clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) (sign of the ACC_W+1 sum). Clamping applies to both `acc` and `out_data`, and the flag is still set.
- Not defined: two's-complement wrap to ACC_W bits, with the flag set.

## Test plan
- Reset, then lanes {1,-1,100,-524288} ×3 beats with last on beat 3 -> `out_valid` on that edge, `out_data` {3,-3,300,-1572864}, `out_cnt=3`, `out_ovf=0`.
- Single-beat group with `in_sum` lane0 = -5 -> `out_data` lane0 = 0xFFFFFFB, `out_cnt=1`.
- `out_ready=0` with a result pending, `in_valid=1` -> `in_ready=0`, result held stable. Raise `out_ready` -> next groups stream out back-to-back, one per last beat, with no bubble.
- Lane0 fed 256 beats of +524287 with ACC_W=28 (overflow on beat 257 only with a longer group; use ACC_W=24 for 17 beats) -> wrap build gives a wrapped value and `ovf[0]=1`; `BF_ACC_SATURATE_EN` build gives 0x7FFFFF and `ovf[0]=1`; the next group's `ovf[0]=0`.
- `clr` pulsed after 2 beats of 7, then 1 last beat of 7 -> `out_data` lane = 7, `out_cnt=1`. The pending output register is unaffected by `clr`.
- `reset_n` low mid-group with `out_valid=1` -> all outputs 0 asynchronously. After release, a fresh group sums from 0.
